// File: rtl/divider32_fp_if.sv
// Request/result bundle for the binary32 divider.
// Master drives the operands and start; slave returns quotient, status and flags.
interface divider32_fp_if;
  logic        start_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic [31:0] quotient_o;
  logic        done_o;
  logic        busy_o;
  logic        nan_o;
  logic        infinit_o;
  logic        overflow_o;
  logic        underflow_o;
  logic        div_by_zero_o;

  modport master (
    output start_i, a_i, b_i,
    input  quotient_o, done_o, busy_o, nan_o,
    input  infinit_o, overflow_o, underflow_o, div_by_zero_o
  );

  modport slave (
    input  start_i, a_i, b_i,
    output quotient_o, done_o, busy_o, nan_o,
    output infinit_o, overflow_o, underflow_o, div_by_zero_o
  );
endinterface

// File: rtl/divider32_fp.sv
// Multi-cycle binary32 divider, one restoring quotient bit per cycle.
// DIV32FP_ROUND_EN selects round-to-nearest-even; otherwise truncate.
module divider32_fp (
  input logic       clk,
  input logic       rst_n,
  divider32_fp_if.slave bus
);

`ifdef DIV32FP_ROUND_EN
  localparam bit RoundEn = 1'b1;
`else
  localparam bit RoundEn = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, UNPACK, DIVIDE, NORMALIZE, ROUND, DONE
  } state_t;

  state_t state;

  logic [31:0] a_q, b_q;
  logic        sign;
  logic signed [9:0] exp_q;
  logic [23:0] mb;
  logic [25:0] rem;
  logic [25:0] quo;
  logic [4:0]  cnt;

  logic [31:0] quotient;
  logic done, busy;
  logic nan, inf, ovf, unf, dbz;

  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic is_nan, is_inf, is_dbz, is_zero;

  always_comb begin
    a_zero = a_q[30:23] == 8'h00;
    b_zero = b_q[30:23] == 8'h00;
    a_inf  = (&a_q[30:23]) && (a_q[22:0] == 23'd0);
    b_inf  = (&b_q[30:23]) && (b_q[22:0] == 23'd0);
    a_nan  = (&a_q[30:23]) && (|a_q[22:0]);
    b_nan  = (&b_q[30:23]) && (|b_q[22:0]);
    is_nan = a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf);
    is_inf = !is_nan && a_inf;
    is_dbz = !is_nan && !a_inf && b_zero;
    is_zero = !is_nan && !a_inf && !b_zero && (a_zero | b_inf);
  end

  logic        inc;
  logic [24:0] mant_r;
  logic [22:0] frac_r;
  logic signed [9:0] exp_r;

  // quo[1] is guard, quo[0] round, remainder gives sticky
  always_comb begin
    inc    = RoundEn & quo[1] & (quo[0] | (|rem) | quo[2]);
    mant_r = {1'b0, quo[25:2]} + {24'd0, inc};
    exp_r  = exp_q;
    frac_r = mant_r[22:0];
    if (mant_r[24]) begin
      frac_r = mant_r[23:1];
      exp_r  = exp_q + 10'sd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      quotient <= 32'd0;
      done     <= 1'b0;
      busy     <= 1'b0;
      nan      <= 1'b0;
      inf      <= 1'b0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
      dbz      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.start_i) begin
            a_q   <= bus.a_i;
            b_q   <= bus.b_i;
            busy  <= 1'b1;
            state <= UNPACK;
          end
        end
        UNPACK: begin
          sign  <= a_q[31] ^ b_q[31];
          exp_q <= $signed({2'b00, a_q[30:23]})
                 - $signed({2'b00, b_q[30:23]})
                 + 10'sd127;
          mb    <= {1'b1, b_q[22:0]};
          rem   <= {3'b001, a_q[22:0]};
          quo   <= 26'd0;
          cnt   <= 5'd0;
          if (is_nan | is_inf | is_dbz | is_zero) begin
            if (is_nan)
              quotient <= 32'h7FC0_0000;
            else if (is_zero)
              quotient <= {a_q[31] ^ b_q[31], 31'd0};
            else
              quotient <= {a_q[31] ^ b_q[31], 8'hFF, 23'd0};
            nan   <= is_nan;
            inf   <= is_inf | is_dbz;
            dbz   <= is_dbz;
            ovf   <= 1'b0;
            unf   <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= DIVIDE;
          end
        end
        DIVIDE: begin
          if (rem >= {2'b00, mb}) begin
            rem <= (rem - {2'b00, mb}) << 1;
            quo <= {quo[24:0], 1'b1};
          end else begin
            rem <= rem << 1;
            quo <= {quo[24:0], 1'b0};
          end
          cnt <= cnt + 5'd1;
          if (cnt == 5'd25)
            state <= NORMALIZE;
        end
        NORMALIZE: begin
          if (!quo[25]) begin
            quo   <= quo << 1;
            exp_q <= exp_q - 10'sd1;
          end
          state <= ROUND;
        end
        ROUND: begin
          nan <= 1'b0;
          dbz <= 1'b0;
          if (exp_r >= 10'sd255) begin
            quotient <= {sign, 8'hFF, 23'd0};
            inf      <= 1'b1;
            ovf      <= 1'b1;
            unf      <= 1'b0;
          end else if (exp_r <= 10'sd0) begin
            quotient <= {sign, 31'd0};
            inf      <= 1'b0;
            ovf      <= 1'b0;
            unf      <= 1'b1;
          end else begin
            quotient <= {sign, exp_r[7:0], frac_r};
            inf      <= 1'b0;
            ovf      <= 1'b0;
            unf      <= 1'b0;
          end
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.quotient_o    = quotient;
  assign bus.done_o        = done;
  assign bus.busy_o        = busy;
  assign bus.nan_o         = nan;
  assign bus.infinit_o     = inf;
  assign bus.overflow_o    = ovf;
  assign bus.underflow_o   = unf;
  assign bus.div_by_zero_o = dbz;

endmodule

// File: tb/tb_divider32_fp.sv
// Directed-vector bench for divider32_fp.
// Flags are compared as {nan, inf, overflow, underflow, div_by_zero}.
module tb_divider32_fp;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;

  divider32_fp_if bus ();

  divider32_fp dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (bus.done_o) done_cnt++;

  function automatic logic [31:0] flags();
    return {27'd0, bus.nan_o, bus.infinit_o, bus.overflow_o,
            bus.underflow_o, bus.div_by_zero_o};
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.a_i = a;
    bus.b_i = b;
    bus.start_i = 1'b1;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_cyc);
    int  n = 0;
    bit  seen = 0;
    while (!seen && n < 60) begin
      @(posedge clk);
      #1 n++;
      if (bus.done_o) seen = 1;
    end
    check({tag, "/lat"}, seen ? 32'(n + 1) : 32'd0, 32'(exp_cyc));
  endtask

  task automatic run_op(input string tag, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_q,
                        input logic [4:0] exp_f, input int exp_cyc);
    start_op(a, b);
    wait_done(tag, exp_cyc);
    check({tag, "/q"}, bus.quotient_o, exp_q);
    check({tag, "/flags"}, flags(), {27'd0, exp_f});
    @(posedge clk);
    #1;
    check({tag, "/pulse"}, {31'd0, bus.done_o}, 32'd0);
    check({tag, "/idle"}, {31'd0, bus.busy_o}, 32'd0);
    check({tag, "/hold"}, bus.quotient_o, exp_q);
  endtask

  localparam logic [4:0] F_NONE = 5'b00000;
  localparam logic [4:0] F_NAN  = 5'b10000;
  localparam logic [4:0] F_INF  = 5'b01000;
  localparam logic [4:0] F_OVF  = 5'b01100;
  localparam logic [4:0] F_UNF  = 5'b00010;
  localparam logic [4:0] F_DBZ  = 5'b01001;

`ifdef DIV32FP_ROUND_EN
  localparam logic [31:0] THIRD  = 32'h3EAA_AAAB;
  localparam logic [31:0] TWO3RD = 32'h3F2A_AAAB;
`else
  localparam logic [31:0] THIRD  = 32'h3EAA_AAAA;
  localparam logic [31:0] TWO3RD = 32'h3F2A_AAAA;
`endif

  initial begin
    int snap;
    rst_n = 1'b0;
    bus.start_i = 1'b0;
    bus.a_i = 32'd0;
    bus.b_i = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst/q", bus.quotient_o, 32'd0);
    check("rst/flags", flags(), 32'd0);
    check("rst/st", {30'd0, bus.done_o, bus.busy_o}, 32'd0);
    rst_n = 1'b1;

    run_op("10div4", 32'h4120_0000, 32'h4080_0000, 32'h4020_0000, F_NONE, 30);
    run_op("1div3", 32'h3F80_0000, 32'h4040_0000, THIRD, F_NONE, 30);
    run_op("1div1.5", 32'h3F80_0000, 32'h3FC0_0000, TWO3RD, F_NONE, 30);
    run_op("6div2", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, F_NONE, 30);
    run_op("neg1div2", 32'hBF80_0000, 32'h4000_0000, 32'hBF00_0000, F_NONE, 30);
    run_op("1div0", 32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, F_DBZ, 2);
    run_op("neg1div0", 32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, F_DBZ, 2);
    run_op("0div0", 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, F_NAN, 2);
    run_op("nan", 32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, F_NAN, 2);
    run_op("infdivinf", 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, F_NAN, 2);
    run_op("infdiv2", 32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, F_INF, 2);
    run_op("2divinf", 32'h4000_0000, 32'h7F80_0000, 32'h0000_0000, F_NONE, 2);
    run_op("0divneg5", 32'h0000_0000, 32'hC0A0_0000, 32'h8000_0000, F_NONE, 2);
    run_op("subnorm", 32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, F_NONE, 2);
    run_op("ovf", 32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, F_OVF, 30);
    run_op("unf", 32'h0080_0000, 32'h4000_0000, 32'h0000_0000, F_UNF, 30);
    run_op("negovf", 32'hFF00_0000, 32'h3E80_0000, 32'hFF80_0000, F_OVF, 30);

    // abort mid-divide, with a start asserted during the reset cycle
    run_op("pre", 32'h4120_0000, 32'h4080_0000, 32'h4020_0000, F_NONE, 30);
    snap = done_cnt;
    start_op(32'h4120_0000, 32'h4080_0000);
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    bus.start_i = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.start_i = 1'b0;
    check("abort/busy", {31'd0, bus.busy_o}, 32'd0);
    check("abort/q", bus.quotient_o, 32'd0);
    check("abort/flags", flags(), 32'd0);
    repeat (40) @(posedge clk);
    #1;
    check("abort/nodone", 32'(done_cnt - snap), 32'd0);
    check("abort/idle", {31'd0, bus.busy_o}, 32'd0);
    run_op("post", 32'h4120_0000, 32'h4080_0000, 32'h4020_0000, F_NONE, 30);

    // start pulses while busy must be ignored
    snap = done_cnt;
    start_op(32'h4120_0000, 32'h4080_0000);
    repeat (4) @(posedge clk);
    #1 bus.a_i = 32'h3F80_0000;
    bus.b_i = 32'h0000_0000;
    bus.start_i = 1'b1;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    wait_done("busy", 30 - 5);
    check("busy/q", bus.quotient_o, 32'h4020_0000);
    check("busy/flags", flags(), 32'd0);
    repeat (40) @(posedge clk);
    #1;
    check("busy/onedone", 32'(done_cnt - snap), 32'd1);

    // start held high through DONE restarts only from IDLE
    snap = done_cnt;
    @(negedge clk);
    bus.a_i = 32'h3F80_0000;
    bus.b_i = 32'h0000_0000;
    bus.start_i = 1'b1;
    repeat (6) @(posedge clk);
    #1 bus.start_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("held/dones", 32'(done_cnt - snap), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
